loop_nest_issuer: RTL and testbench
===================================

LOOP_NEST_ISSUER -- requirements
Module: loop_nest_issuer

Interface
REQ-001 SHALL have parameter N_OUTER, default 2, outer-loop trip count (>=1).
REQ-002 SHALL have parameter N_INNER, default 2, inner-loop trip count (>=1).
REQ-003 SHALL have parameter II, default 1, initiation interval in enabled cycles (>=1).
REQ-004 SHALL have port clk  input  1  clock; all state on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  begin (or restart) the loop nest.
REQ-007 SHALL have port en  input  1  advance enable; low = stall.
REQ-008 SHALL have port valid  output  1  an iteration is issued this cycle.
REQ-009 SHALL have port i  output  32  outer index of the issued iteration.
REQ-010 SHALL have port j  output  32  inner index of the issued iteration.
REQ-011 SHALL have port first  output  1  valid and (i,j)==(0,0).
REQ-012 SHALL have port last  output  1  valid and (i,j)==(N_OUTER-1,N_INNER-1).
REQ-013 SHALL have port busy  output  1  state is RUN.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the last iteration.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; rst dominates start, start dominates en.
REQ-016 SHALL, in IDLE with start high at an edge, enter RUN with i=0, j=0, phase=0 (latency 1: first valid possible the next cycle).
REQ-017 SHALL keep a phase counter 0..II-1, incremented only in RUN cycles with en high, wrapping II-1 -> 0.
REQ-018 SHALL drive valid = busy & en & (phase==0), combinationally.
REQ-019 SHALL hold i, j, phase unchanged in any RUN cycle with en low; valid low then.
REQ-020 SHALL, on a valid cycle, advance j+1; on j==N_INNER-1 wrap j to 0 and advance i+1.
REQ-021 SHALL, on the valid cycle with last high, go to DONE; i, j hold final values.
REQ-022 SHALL assert done for exactly the single DONE cycle, then return to IDLE (or RUN if start is high in that cycle); done still pulses.
REQ-023 SHALL, on start high in RUN, restart: next cycle i=0, j=0, phase=0; no done pulse for the aborted nest; valid in the start cycle still follows REQ-018.
REQ-024 SHALL issue exactly N_OUTER*N_INNER valid pulses per uninterrupted nest, in row-major order.
REQ-025 SHALL, with N_OUTER=N_INNER=1, assert first and last in the same single valid cycle.
REQ-026 SHALL, with II=1 and en held high, issue valid on consecutive cycles with no bubble across j wrap.
REQ-027 SHALL compute all index compares at 32 bits; parameters > 2^31 are unsupported.
REQ-028 SHALL ignore en outside RUN; valid, first, last low in IDLE and DONE.

Reset
REQ-029 SHALL, with rst high at an edge, set state IDLE, i=0, j=0, phase=0, regardless of start/en.
REQ-030 SHALL hold after reset: valid=0, first=0, last=0, busy=0, done=0.
REQ-031 SHALL abandon a nest on reset mid-RUN with no done pulse.

Verification
REQ-032 N_OUTER=2,N_INNER=3,II=1, start at cycle 0, en=1 -> valid cycles 1-6, (i,j)=(0,0),(0,1),(0,2),(1,0),(1,1),(1,2); first at 1, last at 6, done at 7, busy 1-6.
REQ-033 N_OUTER=1,N_INNER=3,II=3, en=1, start at 0 -> valid at cycles 1,4,7; done at 8.
REQ-034 N_OUTER=1,N_INNER=2,II=2, en low cycles 2-3 -> valid at 1 and 5 only; done at 6.
REQ-035 N_OUTER=2,N_INNER=2,II=1, start again at cycle 2 -> valid (0,0),(0,1),(0,0),(0,1),(1,0),(1,1) at 1-6; one done at 7.
REQ-036 N_OUTER=2,N_INNER=2, rst at cycle 3 -> no valid from 3, no done, busy=0 from cycle 4; later start runs full 4 iterations.
REQ-037 N_OUTER=N_INNER=1,II=1, start at 0 and again at 2 -> valid+first+last at 1 and at 3; done at 2 and at 4.

Source files
------------

// File: rtl/loop_nest_issuer.sv
// Two-level loop-nest iteration issuer: walks (i,j) in row-major order,
// one iteration every II enabled cycles, with start/restart and a done pulse.
module loop_nest_issuer #(
  parameter int unsigned N_OUTER = 2,
  parameter int unsigned N_INNER = 2,
  parameter int unsigned II      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        en,
  output logic        valid,
  output logic [31:0] i,
  output logic [31:0] j,
  output logic        first,
  output logic        last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] I_LAST  = 32'(N_OUTER - 1);
  localparam logic [31:0] J_LAST  = 32'(N_INNER - 1);
  localparam logic [31:0] PH_LAST = 32'(II - 1);

  state_t      state;
  logic [31:0] phase;
  logic        at_phase0;
  logic        at_i_first;
  logic        at_j_first;
  logic        at_i_last;
  logic        at_j_last;

  // Index and phase comparisons, all at full 32-bit width.
  always_comb begin
    at_phase0  = (phase == 32'd0);
    at_i_first = (i == 32'd0);
    at_j_first = (j == 32'd0);
    at_i_last  = (i == I_LAST);
    at_j_last  = (j == J_LAST);
  end

  // Issue qualifiers are combinational so a stall suppresses valid in the same cycle.
  always_comb begin
    busy  = (state == RUN);
    done  = (state == DONE);
    valid = busy & en & at_phase0;
    first = valid & at_i_first & at_j_first;
    last  = valid & at_i_last & at_j_last;
  end

  // Control FSM with index and phase counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      i     <= 32'd0;
      j     <= 32'd0;
      phase <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            i     <= 32'd0;
            j     <= 32'd0;
            phase <= 32'd0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (start) begin
            // Restart abandons the current nest without a done pulse.
            state <= RUN;
            i     <= 32'd0;
            j     <= 32'd0;
            phase <= 32'd0;
          end else if (en) begin
            phase <= (phase == PH_LAST) ? 32'd0 : phase + 32'd1;
            if (valid) begin
              if (at_i_last && at_j_last) begin
                state <= DONE;
              end else if (at_j_last) begin
                j <= 32'd0;
                i <= i + 32'd1;
              end else begin
                j <= j + 32'd1;
              end
            end else begin
              state <= RUN;
            end
          end else begin
            state <= RUN;
          end
        end
        DONE: begin
          if (start) begin
            state <= RUN;
            i     <= 32'd0;
            j     <= 32'd0;
            phase <= 32'd0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          i     <= 32'd0;
          j     <= 32'd0;
          phase <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_loop_nest_issuer.sv
// Directed bench: five parameterisations of loop_nest_issuer, each case driven
// cycle by cycle against hand-computed per-cycle bitmasks.
module tb_loop_nest_issuer;

  logic        clk = 1'b0;
  logic [4:0]  rst;
  logic [4:0]  start;
  logic [4:0]  en;
  logic [4:0]  valid;
  logic [4:0]  first;
  logic [4:0]  last;
  logic [4:0]  busy;
  logic [4:0]  done;
  logic [31:0] oi [5];
  logic [31:0] oj [5];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  loop_nest_issuer #(.N_OUTER(2), .N_INNER(3), .II(1)) u0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .en(en[0]), .valid(valid[0]),
    .i(oi[0]), .j(oj[0]), .first(first[0]), .last(last[0]), .busy(busy[0]), .done(done[0]));
  loop_nest_issuer #(.N_OUTER(1), .N_INNER(3), .II(3)) u1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .en(en[1]), .valid(valid[1]),
    .i(oi[1]), .j(oj[1]), .first(first[1]), .last(last[1]), .busy(busy[1]), .done(done[1]));
  loop_nest_issuer #(.N_OUTER(1), .N_INNER(2), .II(2)) u2 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .en(en[2]), .valid(valid[2]),
    .i(oi[2]), .j(oj[2]), .first(first[2]), .last(last[2]), .busy(busy[2]), .done(done[2]));
  loop_nest_issuer #(.N_OUTER(2), .N_INNER(2), .II(1)) u3 (
    .clk(clk), .rst(rst[3]), .start(start[3]), .en(en[3]), .valid(valid[3]),
    .i(oi[3]), .j(oj[3]), .first(first[3]), .last(last[3]), .busy(busy[3]), .done(done[3]));
  loop_nest_issuer #(.N_OUTER(1), .N_INNER(1), .II(1)) u4 (
    .clk(clk), .rst(rst[4]), .start(start[4]), .en(en[4]), .valid(valid[4]),
    .i(oi[4]), .j(oj[4]), .first(first[4]), .last(last[4]), .busy(busy[4]), .done(done[4]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Runs one case on instance k. Bit c of each mask refers to cycle c, where
  // cycle 0 is the first cycle after a one-cycle reset. Status is
  // {valid,first,last,busy,done}; ij holds {i[3:0],j[3:0]} per valid cycle.
  task automatic run_case(input int k, input string name, input int ncyc,
                          input logic [31:0] st, input logic [31:0] en_lo,
                          input logic [31:0] rs, input logic [31:0] v,
                          input logic [31:0] f, input logic [31:0] l,
                          input logic [31:0] b, input logic [31:0] d,
                          input logic [63:0] ij);
    int idx = 0;
    logic [4:0] sts;
    logic [7:0] got_ij;
    rst[k] = 1'b1;
    @(posedge clk); #1;
    rst[k] = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      start[k] = st[c];
      en[k]    = ~en_lo[c];
      rst[k]   = rs[c];
      @(negedge clk);
      sts = {valid[k], first[k], last[k], busy[k], done[k]};
      check($sformatf("%s c%0d status", name, c), 64'(sts),
            64'({v[c], f[c], l[c], b[c], d[c]}));
      if (v[c] && idx < 8) begin
        got_ij = {oi[k][3:0], oj[k][3:0]};
        check($sformatf("%s c%0d ij", name, c), 64'(got_ij), 64'(ij[idx*8 +: 8]));
        idx++;
      end
      @(posedge clk); #1;
    end
    start[k] = 1'b0;
    en[k]    = 1'b1;
    rst[k]   = 1'b0;
  endtask

  initial begin
    rst   = 5'h1F;
    start = 5'h1F;
    en    = 5'h1F;
    @(posedge clk); #1;
    start = 5'h00;
    @(posedge clk); #1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("reset u%0d status", k),
            64'({valid[k], first[k], last[k], busy[k], done[k]}), 64'd0);
      check($sformatf("reset u%0d ij", k), {oi[k], oj[k]}, 64'd0);
    end
    @(posedge clk); #1;
    rst = 5'h00;

    // 2x3, II=1: valid 1-6, done 7
    run_case(0, "n2x3_ii1", 9, 32'h1, 32'h0, 32'h0, 32'h7E, 32'h02, 32'h40,
             32'h7E, 32'h80, 64'h0000_1211_1002_0100);
    // 1x3, II=3: valid 1,4,7, done 8
    run_case(1, "n1x3_ii3", 10, 32'h1, 32'h0, 32'h0, 32'h92, 32'h02, 32'h80,
             32'hFE, 32'h100, 64'h0000_0000_0002_0100);
    // 1x2, II=2, en low cycles 2-3: valid 1,5, done 6
    run_case(2, "n1x2_stall", 8, 32'h1, 32'h0C, 32'h0, 32'h22, 32'h02, 32'h20,
             32'h3E, 32'h40, 64'h0000_0000_0000_0100);
    // 2x2, restart at cycle 2
    run_case(3, "n2x2_restart", 9, 32'h05, 32'h0, 32'h0, 32'h7E, 32'h0A, 32'h40,
             32'h7E, 32'h80, 64'h0000_1110_0100_0100);
    // 2x2, reset at cycle 3 (en low there), new start at cycle 6
    run_case(3, "n2x2_rst", 13, 32'h41, 32'h08, 32'h08, 32'h786, 32'h82, 32'h400,
             32'h78E, 32'h800, 64'h0000_1110_0100_0100);
    // 1x1, start at 0 and again in the DONE cycle 2
    run_case(4, "n1x1_back2back", 6, 32'h05, 32'h0, 32'h0, 32'h0A, 32'h0A, 32'h0A,
             32'h0A, 32'h14, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
